// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//   Registered 1:N stream demultiplexer. Each accepted input beat is steered to
//   one of N output channels, chosen either by in_sel (AUTO=0) or by an internal
//   round-robin pointer (AUTO=1). Every channel owns a one-entry holding
//   register with valid/ready handshaking, so a stalled consumer only blocks
//   beats aimed at its own channel.
//
// Parameters
//   N    number of output channels (2..16)
//   W    payload width
//   AUTO 0: route by in_sel, 1: route by rotating pointer (in_sel ignored)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   input beat accepted when high together with in_valid
//   in_data    input payload
//   in_sel     destination channel (AUTO=0 only)
//   out_valid  per-channel holding register full
//   out_ready  per-channel consumer ready
//   out_data   channel k at [k*W +: W]
//   err_sel    sticky: a beat was dropped because in_sel >= N
//   clr_err    synchronous clear of err_sel (and of beat_cnt when present)
//   beat_cnt   only with STREAM_DEMUX_CNT_EN defined: one saturating 16-bit
//              accepted-beat counter per channel at [k*16 +: 16]
// -----------------------------------------------------------------------------
module stream_demux_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int AUTO = 0,
    localparam int SW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SW-1:0]     in_sel,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [N*W-1:0]    out_data,
    output logic              err_sel,
`ifdef STREAM_DEMUX_CNT_EN
    output logic [N*16-1:0]   beat_cnt,
`endif
    input  logic              clr_err
);

    // N widened by one bit so the range check also works when N = 2**SW.
    localparam logic [SW:0] N_L = (SW+1)'(N);

    logic [SW-1:0] tgt;
    logic          tgt_ok;
    logic [N-1:0]  hit;
    logic [N-1:0]  load;
    logic [N-1:0]  chan_rdy;
    logic          chan_ready;
    logic          accept;
    logic          drop;
    logic          err_q;
    logic          err_d;

    // ---------------------------------------------------------------- target
    generate
        if (AUTO != 0) begin : g_auto
            logic [SW-1:0] ptr_q;
            logic [SW-1:0] ptr_d;

            // Pointer only moves on an accepted beat, so a stalled channel
            // holds it in place rather than being skipped.
            always_comb begin
                ptr_d = ptr_q;
                if (accept) begin
                    ptr_d = (ptr_q == SW'(N-1)) ? '0 : ptr_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end

            assign tgt    = ptr_q;
            assign tgt_ok = 1'b1;
        end else begin : g_sel
            assign tgt    = in_sel;
            assign tgt_ok = ({1'b0, in_sel} < N_L);
        end
    endgenerate

    // in_ready looks only at the target channel; out-of-range beats are
    // always taken so they can be dropped and flagged.
    assign chan_ready = |(hit & chan_rdy);
    assign in_ready   = tgt_ok ? chan_ready : 1'b1;
    assign accept     = in_valid & in_ready;
    assign drop       = accept & ~tgt_ok;

    // -------------------------------------------------------------- channels
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            logic         valid_q;
            logic         valid_d;
            logic [W-1:0] data_q;
            logic [W-1:0] data_d;

            assign hit[gi]      = (tgt == SW'(gi));
            assign load[gi]     = accept & tgt_ok & hit[gi];
            assign chan_rdy[gi] = ~valid_q | out_ready[gi];

            // Load takes priority over drain so a simultaneous drain+load
            // keeps the channel full with the new beat.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (load[gi]) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (valid_q && out_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid[gi]         = valid_q;
            assign out_data[gi*W +: W]   = data_q;

`ifdef STREAM_DEMUX_CNT_EN
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_err) begin
                    cnt_d = '0;
                end else if (load[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign beat_cnt[gi*16 +: 16] = cnt_q;
`endif
        end
    endgenerate

    // ------------------------------------------------------------ error flag
    // A drop in the same cycle as clr_err leaves the flag set.
    always_comb begin
        err_d = err_q;
        if (drop) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sel = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_n
//   Directed bench for stream_demux_n. Three instances:
//     u_dut   N=4 AUTO=0  routing, streaming, backpressure (and counters when
//                         STREAM_DEMUX_CNT_EN is defined)
//     u_auto  N=3 AUTO=1  round-robin pointer and pointer stall
//     u_bad   N=3 AUTO=0  out-of-range select and err_sel handling
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---- N=4, AUTO=0
    logic        a_in_valid, a_in_ready, a_err_sel, a_clr_err;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [63:0] a_beat_cnt;
`endif

    // ---- N=3, AUTO=1
    logic        b_in_valid, b_in_ready, b_err_sel, b_clr_err;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [47:0] b_beat_cnt;
`endif

    // ---- N=3, AUTO=0
    logic        c_in_valid, c_in_ready, c_err_sel, c_clr_err;
    logic [7:0]  c_in_data;
    logic [1:0]  c_in_sel;
    logic [2:0]  c_out_valid, c_out_ready;
    logic [23:0] c_out_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [47:0] c_beat_cnt;
`endif

    stream_demux_n #(.N(4), .W(8), .AUTO(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .err_sel   (a_err_sel),
`ifdef STREAM_DEMUX_CNT_EN
        .beat_cnt  (a_beat_cnt),
`endif
        .clr_err   (a_clr_err)
    );

    stream_demux_n #(.N(3), .W(8), .AUTO(1)) u_auto (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .err_sel   (b_err_sel),
`ifdef STREAM_DEMUX_CNT_EN
        .beat_cnt  (b_beat_cnt),
`endif
        .clr_err   (b_clr_err)
    );

    stream_demux_n #(.N(3), .W(8), .AUTO(0)) u_bad (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .in_sel    (c_in_sel),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .err_sel   (c_err_sel),
`ifdef STREAM_DEMUX_CNT_EN
        .beat_cnt  (c_beat_cnt),
`endif
        .clr_err   (c_clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 4'hF; a_clr_err = 0;
        b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 3'h7; b_clr_err = 0;
        c_in_valid = 0; c_in_data = 0; c_in_sel = 0; c_out_ready = 3'h7; c_clr_err = 0;
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // ---------------- reset mid-transfer
        a_in_valid = 1; a_in_sel = 2'd0; a_in_data = 8'h5A;
        step();
        a_in_valid = 0; a_out_ready = 4'h0;
        chk("pre_rst_valid", 32'(a_out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_out_data",  a_out_data, 32'h0);
        chk("rst_err_sel",   32'(a_err_sel), 32'h0);
        chk("rst_b_valid",   32'(b_out_valid), 32'h0);
        chk("rst_c_err",     32'(c_err_sel), 32'h0);
        for (int s = 0; s < 4; s++) begin
            a_in_sel = 2'(s);
            #1 chk($sformatf("rst_in_ready_sel%0d", s), 32'(a_in_ready), 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 4'hF;

        // ---------------- routing and back-to-back streaming to sel 2
        a_in_valid = 1; a_in_sel = 2'd2; a_in_data = 8'hA5;
        #1 chk("s2_in_ready", 32'(a_in_ready), 32'h1);
        step();
        chk("s2_valid_a5", 32'(a_out_valid), 32'h4);
        chk("s2_data_a5",  32'(a_out_data[23:16]), 32'hA5);
        a_in_data = 8'hB2;
        step();
        chk("s2_valid_b2", 32'(a_out_valid), 32'h4);
        chk("s2_data_b2",  32'(a_out_data[23:16]), 32'hB2);
        a_in_data = 8'hC3;
        step();
        chk("s2_data_c3",  32'(a_out_data[23:16]), 32'hC3);
        a_in_valid = 0;
        step();
        chk("s2_drained",  32'(a_out_valid), 32'h0);
        chk("s2_data_kept", 32'(a_out_data[23:16]), 32'hC3);

        // ---------------- backpressure on channel 1
        a_out_ready = 4'b1101;
        a_in_valid = 1; a_in_sel = 2'd1; a_in_data = 8'h11;
        step();
        chk("bp_valid_11", 32'(a_out_valid), 32'h2);
        chk("bp_data_11",  32'(a_out_data[15:8]), 32'h11);
        a_in_data = 8'h22;
        #1 chk("bp_stall_ready", 32'(a_in_ready), 32'h0);
        step();
        chk("bp_hold_11",  32'(a_out_data[15:8]), 32'h11);
        chk("bp_still_stall", 32'(a_in_ready), 32'h0);
        a_in_sel = 2'd3; a_in_data = 8'h33;
        #1 chk("bp_sel3_ready", 32'(a_in_ready), 32'h1);
        step();
        chk("bp_valid_13", 32'(a_out_valid), 32'hA);
        chk("bp_data_33",  32'(a_out_data[31:24]), 32'h33);
        chk("bp_hold2_11", 32'(a_out_data[15:8]), 32'h11);
        a_in_sel = 2'd1; a_in_data = 8'h22; a_out_ready = 4'hF;
        #1 chk("bp_release_ready", 32'(a_in_ready), 32'h1);
        step();
        chk("bp_valid_22", 32'(a_out_valid), 32'h2);
        chk("bp_data_22",  32'(a_out_data[15:8]), 32'h22);
        a_in_valid = 0;
        step();
        chk("bp_idle",     32'(a_out_valid), 32'h0);

        // ---------------- round robin, N=3
        b_in_valid = 1;
        for (int k = 1; k <= 6; k++) begin
            b_in_data = 8'(k);
            step();
            chk($sformatf("rr_beat%0d_data", k), 32'(b_out_data[((k-1)%3)*8 +: 8]), 32'(k));
            chk($sformatf("rr_beat%0d_valid", k), 32'(b_out_valid), 32'(1 << ((k-1)%3)));
        end
        b_in_valid = 0; b_out_ready = 3'b101;
        step();
        b_in_valid = 1;
        b_in_data = 8'd7;  step(); chk("rr_b7_ch0",  32'(b_out_data[7:0]),   32'd7);
        b_in_data = 8'd8;  step(); chk("rr_b8_ch1",  32'(b_out_data[15:8]),  32'd8);
        b_in_data = 8'd9;  step(); chk("rr_b9_ch2",  32'(b_out_data[23:16]), 32'd9);
        b_in_data = 8'd10; step(); chk("rr_b10_ch0", 32'(b_out_data[7:0]),   32'd10);
        chk("rr_b10_valid", 32'(b_out_valid), 32'b011);
        b_in_data = 8'd11;
        #1 chk("rr_stall_ready", 32'(b_in_ready), 32'h0);
        step();
        chk("rr_stall_valid", 32'(b_out_valid), 32'b010);
        chk("rr_stall_ch1",   32'(b_out_data[15:8]), 32'd8);
        step();
        chk("rr_stall_ch0",   32'(b_out_data[7:0]),   32'd10);
        chk("rr_stall_ch2",   32'(b_out_data[23:16]), 32'd9);
        chk("rr_stall_valid2", 32'(b_out_valid), 32'b010);
        b_out_ready = 3'b111;
        #1 chk("rr_release_ready", 32'(b_in_ready), 32'h1);
        step();
        chk("rr_ch1_11",      32'(b_out_data[15:8]), 32'd11);
        chk("rr_ch1_valid",   32'(b_out_valid), 32'b010);
        b_in_valid = 0;
        step();
        chk("rr_idle",        32'(b_out_valid), 32'h0);

        // ---------------- out-of-range select, N=3
        c_in_valid = 1; c_in_sel = 2'd3; c_in_data = 8'hEE;
        #1 chk("bad_in_ready", 32'(c_in_ready), 32'h1);
        chk("bad_err_before", 32'(c_err_sel), 32'h0);
        step();
        chk("bad_no_valid", 32'(c_out_valid), 32'h0);
        chk("bad_err_set",  32'(c_err_sel), 32'h1);
        c_clr_err = 1;
        step();
        chk("bad_set_wins", 32'(c_err_sel), 32'h1);
        c_in_valid = 0;
        step();
        chk("bad_cleared",  32'(c_err_sel), 32'h0);
        c_clr_err = 0;
        c_in_valid = 1; c_in_sel = 2'd2; c_in_data = 8'h5C;
        step();
        c_in_valid = 0;
        chk("bad_good_valid", 32'(c_out_valid), 32'b100);
        chk("bad_good_data",  32'(c_out_data[23:16]), 32'h5C);
        chk("bad_good_err",   32'(c_err_sel), 32'h0);

`ifdef STREAM_DEMUX_CNT_EN
        // ---------------- counter saturation
        a_clr_err = 1;
        step();
        a_clr_err = 0;
        chk("cnt_cleared0", a_beat_cnt[31:0], 32'h0);
        a_in_valid = 1; a_in_sel = 2'd0; a_in_data = 8'h01; a_out_ready = 4'hF;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        chk("cnt_ch0_sat", 32'(a_beat_cnt[15:0]),  32'hFFFF);
        chk("cnt_ch1",     32'(a_beat_cnt[31:16]), 32'h0);
        chk("cnt_ch23",    a_beat_cnt[63:32], 32'h0);
        a_clr_err = 1;
        step();
        a_clr_err = 0;
        chk("cnt_clr_lo",  a_beat_cnt[31:0],  32'h0);
        chk("cnt_clr_hi",  a_beat_cnt[63:32], 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered 1:N stream demultiplexer; successor to the team's combinational 1:4 demux.
- Routes each accepted input beat to one of N output channels, selected by port or by internal round-robin pointer.
- Each channel has a one-entry holding register with valid/ready backpressure.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- N, 4, number of output channels (2..16).
- W, 8, data width in bits.
- AUTO, 0, 0 = route by in_sel; 1 = ignore in_sel and route by an internal rotating pointer.
- SW (localparam), $clog2(N), select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- in_data  input  W  input payload.
- in_sel  input  SW  destination channel; ignored when AUTO=1.
- out_valid  output  N  per-channel holding register full.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  N*W  channel k occupies bits [k*W +: W].
- err_sel  output  1  sticky flag: a beat was dropped because in_sel >= N.
- clr_err  input  1  synchronous clear of err_sel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, err_sel = 0, round-robin pointer ptr = 0.
  - Takes effect mid-transfer; any held beats are lost.
- Target channel t:
  - t = in_sel when AUTO = 0.
  - t = ptr when AUTO = 1.
- in_ready:
  - Combinational: in_ready = ~out_valid[t] | out_ready[t].
  - Forced to 1 when t >= N (AUTO = 0 only).
  - Depends only on channel t; a stalled channel never blocks beats to other channels.
- Accept: in_valid & in_ready at a clock edge.
  - If t < N: reg[t] <= in_data and out_valid[t] <= 1.
  - Latency is 1 cycle: data appears on out_data[t] the cycle after acceptance.
- Drain: out_valid[k] & out_ready[k] at an edge clears out_valid[k], unless channel k is reloaded at the same edge.
  - Simultaneous drain and load keeps out_valid[k] = 1 with the new data, giving full throughput of one beat per cycle per channel.
- out_data[k] holds its value while out_valid[k] = 1 and out_ready[k] = 0. It is not cleared on drain.
- AUTO = 1 pointer:
  - ptr advances by 1 after each accepted beat, wrapping from N-1 to 0.
  - ptr holds while the target channel is stalled; there is no skipping.
- Out-of-range select (AUTO = 0, t >= N, only possible when N is not a power of 2):
  - Beat is accepted and discarded; no channel changes.
  - err_sel <= 1.
  - clr_err clears err_sel. If a set and clr_err occur in the same cycle, set wins.
- in_sel and in_data must be stable while in_valid = 1 and in_ready = 0; the block does not check this.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN
- Defined:
  - Adds output port beat_cnt, width N*16, one 16-bit counter per channel at [k*16 +: 16].
  - Counter k increments on each beat accepted for channel k and saturates at 16'hFFFF.
  - Counters reset to 0 on rst_n and are cleared synchronously by clr_err.
  - Dropped out-of-range beats are not counted.
- Undefined: port beat_cnt and all counter logic are absent; other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low asserted mid-cycle -> out_valid = 4'b0000, out_data = 0, err_sel = 0 immediately; in_ready = 1 for every in_sel.
- N=4, AUTO=0, all out_ready=1: send 8'hA5 to sel 2 -> out_valid = 4'b0100 and out_data[23:16] = 8'hA5 exactly one cycle later; back-to-back beats to sel 2 stream at one per cycle.
- Backpressure: out_ready[1]=0, one beat 8'h11 to sel 1 -> a second beat to sel 1 sees in_ready = 0 and the held 8'h11 is stable; a beat to sel 3 in the same stall is accepted; raising out_ready[1] drains 8'h11 and the second beat lands the same edge.
- AUTO=1, N=3: six beats 1..6 -> channels receive 0:{1,4}, 1:{2,5}, 2:{3,6}; with out_ready[1]=0 held, the pointer stalls at 1 and channels 0 and 2 receive nothing further.
- N=3, AUTO=0, in_sel=3: beat accepted, no out_valid bit set, err_sel = 1 next cycle; clr_err together with a second bad beat leaves err_sel = 1; clr_err alone gives 0.
- With STREAM_DEMUX_CNT_EN: 70000 beats to channel 0 -> beat_cnt[15:0] = 16'hFFFF (saturated) and other counters 0; clr_err returns all counters to 0.
